// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BAUD_W = 14;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CTRL_W = 3;

    // Default UART register map
    localparam logic [ADDR_W-1:0] UART_DATA_ADDR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] UART_CTRL_ADDR = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] UART_BAUD_ADDR = 32'h0000_000C;

    // Bit positions inside the control register
    localparam int unsigned CTRL_TX_EN_BIT    = 0;
    localparam int unsigned CTRL_TWO_STOP_BIT = 1;
    localparam int unsigned CTRL_ODD_PAR_BIT  = 2;

    typedef enum logic [2:0] {
        CFG_BAUD = 3'd0,
        CFG_CTRL = 3'd1,
        ARB      = 3'd2,
        WRITE    = 3'd3,
        GAP      = 3'd4
    } tx_sched_state_e;

    // Configuration captured from the cfg_* inputs
    typedef struct packed {
        logic [BAUD_W-1:0] baud;
        logic              two_stop;
        logic              odd_par;
    } cfg_shadow_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshake plus UART register-write bus of the scheduler.
interface uart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [uart_pkg::BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                frame_done;
    logic [uart_pkg::ADDR_W-1:0]         addr;
    logic                                wr_en;
    logic [uart_pkg::BYTE_W-1:0]         raw_data;
    logic [uart_pkg::BAUD_W-1:0]         baud_divisor;
    logic                                Tx_en;
    logic                                Two_stop;
    logic                                Odd_parity;

    // Environment side: producers and UART
    modport master (
        output req_valid, req_data, frame_done,
        input  req_ready, addr, wr_en, raw_data, baud_divisor, Tx_en, Two_stop, Odd_parity
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_data, frame_done,
        output req_ready, addr, wr_en, raw_data, baud_divisor, Tx_en, Two_stop, Odd_parity
    );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [PTR_W-1:0] idx_c,
    output logic             any_c
);

    // Scan requesters starting at ptr, wrapping modulo N
    always_comb begin
        logic [PTR_W-1:0] j;
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = PTR_W'((32'(ptr) + k) % N);
            if (!any_c && req[j]) begin
                any_c      = 1'b1;
                grant_c[j] = 1'b1;
                idx_c      = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Programs the UART after reset / on request and shares its Tx FIFO between requesters.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned       NUM_REQ    = 2,
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] DATA_ADDR  = UART_DATA_ADDR,
    parameter logic [ADDR_W-1:0] CTRL_ADDR  = UART_CTRL_ADDR,
    parameter logic [ADDR_W-1:0] BAUD_ADDR  = UART_BAUD_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_sched_if.slave    bus,
    input  logic [BAUD_W-1:0] cfg_baud,
    input  logic              cfg_two_stop,
    input  logic              cfg_odd_par,
    input  logic              cfg_update,
    output logic              busy
);

    localparam int unsigned       PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned       CRED_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);

    tx_sched_state_e   state_q, state_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              pend_cfg_q, pend_cfg_d;
    logic              boot_q, boot_d;
    cfg_shadow_t       shadow_q, shadow_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [BYTE_W-1:0] raw_data_q, raw_data_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              busy_q, busy_d;

    logic [NUM_REQ-1:0] grant_c;
    logic [PTR_W-1:0]   win_c;
    logic               any_c;
    logic               grant_ok_c;
    logic               go_cfg_c;
    logic [NUM_REQ-1:0] req_ready_c;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .grant_c (grant_c),
        .idx_c   (win_c),
        .any_c   (any_c)
    );

    // Grant only when no reprogram is pending and the FIFO has room
    assign grant_ok_c = (state_q == ARB) && !pend_cfg_q && (credits_q != '0) && any_c;
    // Reprogram once every queued frame has left the FIFO
    assign go_cfg_c   = (state_q == ARB) && pend_cfg_q && (credits_q == CRED_FULL);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= CFG_BAUD;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CFG_BAUD: state_d = CFG_CTRL;
            CFG_CTRL: state_d = ARB;
            ARB: begin
                if (go_cfg_c)        state_d = CFG_BAUD;
                else if (grant_ok_c) state_d = WRITE;
            end
            WRITE:    state_d = GAP;
            GAP:      state_d = ARB;
            default:  state_d = CFG_BAUD;
        endcase
    end

    // Output and datapath next values; bus writes appear the cycle after they are decided
    always_comb begin
        addr_d      = '0;
        wr_en_d     = 1'b0;
        raw_data_d  = raw_data_q;
        baud_d      = baud_q;
        ctrl_d      = ctrl_q;
        rr_ptr_d    = rr_ptr_q;
        pend_cfg_d  = pend_cfg_q;
        boot_d      = boot_q;
        shadow_d    = shadow_q;
        credits_d   = credits_q;
        req_ready_c = '0;

        unique case (state_q)
            CFG_BAUD: begin
                addr_d  = BAUD_ADDR;
                wr_en_d = 1'b1;
                if (boot_q) begin
                    baud_d   = cfg_baud;
                    shadow_d = '{baud: cfg_baud, two_stop: cfg_two_stop, odd_par: cfg_odd_par};
                    boot_d   = 1'b0;
                end else begin
                    baud_d   = shadow_q.baud;
                end
            end
            CFG_CTRL: begin
                addr_d                    = CTRL_ADDR;
                wr_en_d                   = 1'b1;
                ctrl_d[CTRL_TX_EN_BIT]    = 1'b1;
                ctrl_d[CTRL_TWO_STOP_BIT] = shadow_q.two_stop;
                ctrl_d[CTRL_ODD_PAR_BIT]  = shadow_q.odd_par;
            end
            ARB: begin
                if (go_cfg_c) begin
                    pend_cfg_d = 1'b0;
                end else if (grant_ok_c) begin
                    req_ready_c = grant_c;
                    addr_d      = DATA_ADDR;
                    wr_en_d     = 1'b1;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (grant_c[i]) raw_data_d = bus.req_data[i*BYTE_W +: BYTE_W];
                    end
                    rr_ptr_d = (win_c == PTR_W'(NUM_REQ - 1)) ? '0 : win_c + PTR_W'(1);
                end
            end
            default: ;
        endcase

        // Credit accounting: a write and a returned frame in the same cycle cancel out
        if ((state_q == WRITE) && !bus.frame_done) begin
            credits_d = credits_q - CRED_W'(1);
        end else if ((state_q != WRITE) && bus.frame_done && (credits_q != CRED_FULL)) begin
            credits_d = credits_q + CRED_W'(1);
        end

        if (cfg_update) begin
            pend_cfg_d = 1'b1;
            shadow_d   = '{baud: cfg_baud, two_stop: cfg_two_stop, odd_par: cfg_odd_par};
        end

        busy_d = !((state_d == ARB) && (credits_d == CRED_FULL));
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            credits_q  <= CRED_FULL;
            rr_ptr_q   <= '0;
            pend_cfg_q <= 1'b0;
            boot_q     <= 1'b1;
            shadow_q   <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            raw_data_q <= '0;
            baud_q     <= '0;
            ctrl_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            rr_ptr_q   <= rr_ptr_d;
            pend_cfg_q <= pend_cfg_d;
            boot_q     <= boot_d;
            shadow_q   <= shadow_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            raw_data_q <= raw_data_d;
            baud_q     <= baud_d;
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.addr         = addr_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.raw_data     = raw_data_q;
    assign bus.baud_divisor = baud_q;
    assign bus.Tx_en        = ctrl_q[CTRL_TX_EN_BIT];
    assign bus.Two_stop     = ctrl_q[CTRL_TWO_STOP_BIT];
    assign bus.Odd_parity   = ctrl_q[CTRL_ODD_PAR_BIT];
    assign busy             = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with hand-computed expectations.
module tb_uart_tx_sched;

    logic        clk;
    logic        reset;
    logic [13:0] cfg_baud;
    logic        cfg_two_stop;
    logic        cfg_odd_par;
    logic        cfg_update;
    logic        busy;
    int          total;
    int          bad;

    uart_tx_sched_if #(.NUM_REQ(2)) bus ();

    uart_tx_sched #(
        .NUM_REQ    (2),
        .FIFO_DEPTH (8),
        .DATA_ADDR  (32'h0),
        .CTRL_ADDR  (32'h4),
        .BAUD_ADDR  (32'hC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cfg_baud     (cfg_baud),
        .cfg_two_stop (cfg_two_stop),
        .cfg_odd_par  (cfg_odd_par),
        .cfg_update   (cfg_update),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_raw;
        total = 0;
        bad   = 0;
        reset          = 1'b0;
        cfg_baud       = 14'd10;
        cfg_two_stop   = 1'b1;
        cfg_odd_par    = 1'b0;
        cfg_update     = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_data   = 16'h0000;
        bus.frame_done = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_en", bus.Tx_en, 0);
        check("rst_baud", bus.baud_divisor, 0);
        check("rst_ready", bus.req_ready, 0);

        // 1: configuration sequence after reset release
        reset = 1'b1;
        step();
        check("t1_baud_wr", bus.wr_en, 1);
        check("t1_baud_addr", bus.addr, 32'hC);
        check("t1_baud_val", bus.baud_divisor, 10);
        check("t1_baud_busy", busy, 1);
        step();
        check("t1_ctrl_wr", bus.wr_en, 1);
        check("t1_ctrl_addr", bus.addr, 32'h4);
        check("t1_ctrl_tx_en", bus.Tx_en, 1);
        check("t1_ctrl_two_stop", bus.Two_stop, 1);
        check("t1_ctrl_odd", bus.Odd_parity, 0);
        check("t1_ctrl_busy", busy, 0);
        step();
        check("t1_idle_wr", bus.wr_en, 0);
        check("t1_idle_addr", bus.addr, 0);
        check("t1_tx_en_held", bus.Tx_en, 1);

        // 2: both requesters, alternating grants until credits run out
        bus.req_valid = 2'b11;
        for (int g = 0; g < 8; g++) begin
            bus.req_data = {8'hB0 + 8'(g), 8'hA0 + 8'(g)};
            #1;
            check("t2_ready", bus.req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            exp_raw = (g % 2 == 0) ? 8'hA0 + 8'(g) : 8'hB0 + 8'(g);
            step();
            check("t2_wr", bus.wr_en, 1);
            check("t2_addr", bus.addr, 32'h0);
            check("t2_raw", bus.raw_data, exp_raw);
            check("t2_busy", busy, 1);
            step();
            check("t2_gap_wr", bus.wr_en, 0);
            step();
        end
        #1;
        check("t2_empty_ready", bus.req_ready, 0);
        check("t2_empty_busy", busy, 1);
        step();
        check("t2_empty_wr", bus.wr_en, 0);
        check("t2_empty_ready2", bus.req_ready, 0);

        // 3: one returned credit, then frame_done coinciding with WRITE
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        #1;
        check("t3_one_grant", bus.req_ready, 2'b01);
        step();
        check("t3_wr", bus.wr_en, 1);
        check("t3_raw", bus.raw_data, 8'hA7);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        step();
        #1;
        check("t3_credit_kept", bus.req_ready, 2'b10);
        step();
        check("t3_raw2", bus.raw_data, 8'hB7);
        step();
        step();
        #1;
        check("t3_drained_ready", bus.req_ready, 0);
        check("t3_drained_busy", busy, 1);

        // 4: reprogram request with 3 frames still in flight
        bus.req_valid  = 2'b00;
        bus.frame_done = 1'b1;
        repeat (5) step();
        bus.frame_done = 1'b0;
        check("t4_five_busy", busy, 1);
        cfg_baud     = 14'd20;
        cfg_two_stop = 1'b0;
        cfg_odd_par  = 1'b1;
        cfg_update   = 1'b1;
        step();
        cfg_update    = 1'b0;
        cfg_baud      = 14'd99;
        bus.req_valid = 2'b11;
        #1;
        check("t4_blocked", bus.req_ready, 0);
        for (int k = 0; k < 3; k++) begin
            bus.frame_done = 1'b1;
            step();
            bus.frame_done = 1'b0;
            #1;
            check("t4_drain_ready", bus.req_ready, 0);
            check("t4_drain_wr", bus.wr_en, 0);
        end
        step();
        check("t4_pre_cfg_wr", bus.wr_en, 0);
        check("t4_pre_cfg_busy", busy, 1);
        step();
        check("t4_baud_wr", bus.wr_en, 1);
        check("t4_baud_addr", bus.addr, 32'hC);
        check("t4_baud_val", bus.baud_divisor, 20);
        step();
        check("t4_ctrl_addr", bus.addr, 32'h4);
        check("t4_ctrl_tx_en", bus.Tx_en, 1);
        check("t4_ctrl_two_stop", bus.Two_stop, 0);
        check("t4_ctrl_odd", bus.Odd_parity, 1);
        check("t4_ctrl_busy", busy, 0);
        #1;
        check("t4_resume_ready", bus.req_ready, 2'b01);

        // 5: reset during a data write
        step();
        check("t5_mid_wr", bus.wr_en, 1);
        check("t5_mid_raw", bus.raw_data, 8'hA7);
        reset         = 1'b0;
        cfg_baud      = 14'd33;
        cfg_two_stop  = 1'b1;
        cfg_odd_par   = 1'b1;
        bus.req_valid = 2'b00;
        step();
        check("t5_abort_wr", bus.wr_en, 0);
        check("t5_abort_addr", bus.addr, 0);
        check("t5_abort_tx_en", bus.Tx_en, 0);
        check("t5_abort_busy", busy, 0);
        reset = 1'b1;
        step();
        check("t5_baud_addr", bus.addr, 32'hC);
        check("t5_baud_val", bus.baud_divisor, 33);
        step();
        check("t5_ctrl_addr", bus.addr, 32'h4);
        check("t5_ctrl_two_stop", bus.Two_stop, 1);
        check("t5_ctrl_odd", bus.Odd_parity, 1);
        step();
        check("t5_idle_wr", bus.wr_en, 0);
        check("t5_credits_full", busy, 0);

        // 6: only requester 1 active, pointer wraps back to 0
        bus.req_valid = 2'b10;
        bus.req_data  = {8'h5A, 8'hC3};
        #1;
        check("t6_ready1", bus.req_ready, 2'b10);
        step();
        check("t6_raw1", bus.raw_data, 8'h5A);
        step();
        step();
        bus.req_data = {8'h6B, 8'hC3};
        #1;
        check("t6_ready2", bus.req_ready, 2'b10);
        step();
        check("t6_raw2", bus.raw_data, 8'h6B);
        step();
        step();
        bus.req_valid = 2'b11;
        #1;
        check("t6_ptr_wrapped", bus.req_ready, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
